conv_window_addr_gen: RTL and testbench
=======================================

Name: conv_window_addr_gen

Overview:
- Streaming front end that feeds the line-buffer memory stage of the convolution pipeline.
- Accepts one input sample per cycle over a valid/ready handshake and writes it into the circular buffer.
- Once READ_ADDR_LEN samples of the current frame are stored, it presents the READ_ADDR_LEN read addresses of the sliding window, plus valid/last, to the downstream MAC stage.
- Handles frame boundaries, back-pressure and address wrap-around.

Parameters:
MEMORY_SIZE, 24, depth of circular buffer; must satisfy READ_ADDR_LEN < MEMORY_SIZE <= 2**INPUT_PREC
READ_ADDR_LEN, 8, window length K (number of taps / read ports)
INPUT_PREC, 8, sample width and address width

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  input sample valid
in_ready  out  1  block accepts sample this cycle
in_data  in  INPUT_PREC  input sample
in_last  in  1  sample is last of frame
wr_en  out  1  memory write enable
wr_addr  out  INPUT_PREC  memory write address
wr_data  out  INPUT_PREC  memory write data
read_addr  out  INPUT_PREC x READ_ADDR_LEN  window addresses; index 0 = oldest sample
out_valid  out  1  window addresses valid
out_ready  in  1  downstream consumes window
out_last  out  1  window ends with frame's last sample

Interface: one clock; reset is synchronous and active-low. The clock port is clk and the reset port is rst.

Behaviour:
- Reset: when rst=0 at a posedge, the block enters the following state:
  - state=FILL, cnt=0, wr_ptr=0, out_valid=0, out_last=0, all read_addr=0.
  - in_ready and wr_en are forced to 0 combinationally while rst=0.
  - A reset mid-frame discards the partial frame and any pending window.
- in_ready = rst & (!out_valid | out_ready).
- Accept = in_valid & in_ready.
- Write path is combinational: wr_en=accept, wr_addr=wr_ptr, wr_data=in_data. The memory captures the sample on the same edge.
- wr_ptr increments on accept and wraps MEMORY_SIZE-1 -> 0. It is not reset at frame boundaries.
- cnt counts samples in the current frame, saturating at K.
- A window fires on accept when cnt+1 >= K. On that edge:
  - out_valid<=1 and out_last<=in_last.
  - read_addr[i] <= (wr_ptr - (K-1) + i) mod MEMORY_SIZE, using add-MEMORY_SIZE-then-compare wrap arithmetic with no modulo operator.
- Latency: the window is valid one cycle after the accept of its newest sample. Read data from memory is valid in that same cycle, because memory reads are combinational.
- FSM:
  - FILL: cnt < K-1. An accept increments cnt and produces no window. When cnt reaches K-1 the state moves to RUN.
  - RUN: every accept fires a window.
  - An accept with in_last=1 in either state sets cnt<=0 and returns to FILL.
  - A frame shorter than K samples produces no window and is silently dropped.
- Output handshake:
  - out_valid & !out_ready holds read_addr, out_valid and out_last stable; in_ready=0.
  - out_valid & out_ready with a simultaneous firing accept loads the new window on the same edge (full throughput, 1 window/cycle).
  - out_valid & out_ready with no firing accept clears out_valid and out_last.
- Overwrite safety: MEMORY_SIZE > K guarantees the write slot never aliases a held window.

Optional Feature:
CONV_WINDOW_PERF_CNT_EN
- When defined, adds two output ports, each 32 bits, both reset to 0:
  - perf_windows: counts out_valid&out_ready handshakes.
  - perf_stalls: counts cycles with out_valid&!out_ready.
- Both counters wrap at 2**32.
- When undefined, the ports and the counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package conv_pkg holds:
  - typedef addr_t (logic [INPUT_PREC-1:0]);
  - enum state_t {FILL, RUN};
  - a helper function wrap_sub(addr, off, size) returning the wrapped address.
- One sub-module is natural: conv_ring_ptr, the wrapping write-pointer counter with an increment enable.

Test Plan:
- Stream samples 1..10 (in_last on 10), out_ready=1 -> no window before the 8th accept. Windows appear the cycle after accepts 8, 9, 10 with read_addr[0..7] = 0..7, 1..8, 2..9. out_last=1 only on the third window.
- Stream 30 continuous samples -> wr_ptr wraps 23->0. The window after sample 26 (wr_ptr=1) has read_addr = 18,19,20,21,22,23,0,1.
- Hold out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, read_addr stable, no wr_en. On release, throughput resumes at 1 window/cycle.
- Send a 5-sample frame with in_last on the 5th, then an 8-sample frame -> no window for frame 1. The first window of frame 2 covers exactly frame 2's 8 samples (read_addr 5..12).
- Assert rst=0 mid-frame after 6 samples, then stream 8 new samples -> out_valid=0 during reset. The first window appears after the 8th post-reset sample with read_addr 0..7.
- With CONV_WINDOW_PERF_CNT_EN defined, run scenario 3 -> perf_stalls=5 and perf_windows equals the total number of handshakes.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution window address generator.
// Provides the address type, the FILL/RUN state encoding and the circular
// address subtraction used to build sliding-window read addresses.
package conv_pkg;

  localparam int ADDR_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // (addr - off) mod size without a modulo operator: bias by size, then fold
  // back once. Valid for addr < size and off <= size.
  function automatic int unsigned wrap_sub(input int unsigned addr,
                                           input int unsigned off,
                                           input int unsigned size);
    int unsigned s;
    s = addr + size - off;
    if (s >= size) s = s - size;
    return s;
  endfunction

endpackage

// File: rtl/conv_ring_ptr.sv
// Wrapping write-pointer counter for the circular line buffer.
// Advances by one on i_inc and wraps SIZE-1 -> 0.
module conv_ring_ptr #(
  parameter int SIZE = 24,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  localparam logic [W-1:0] LAST = W'(SIZE - 1);

  logic [W-1:0] r_ptr;

  // Pointer register: cleared by reset, advances and wraps on each increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/conv_window_addr_gen.sv
// Streaming front end for the convolution line buffer. Writes each accepted
// sample into a circular buffer and, once a frame holds READ_ADDR_LEN samples,
// presents the window read addresses (index 0 = oldest) to the MAC stage.
// Optional build macro CONV_WINDOW_PERF_CNT_EN adds 32-bit handshake and stall
// counters on ports perf_windows / perf_stalls.
module conv_window_addr_gen #(
  parameter int MEMORY_SIZE   = 24,
  parameter int READ_ADDR_LEN = 8,
  parameter int INPUT_PREC    = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [INPUT_PREC-1:0]                   in_data,
  input  logic                                    in_last,
  output logic                                    wr_en,
  output logic [INPUT_PREC-1:0]                   wr_addr,
  output logic [INPUT_PREC-1:0]                   wr_data,
  output logic [READ_ADDR_LEN-1:0][INPUT_PREC-1:0] read_addr,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic                                    out_last
`ifdef CONV_WINDOW_PERF_CNT_EN
  ,
  output logic [31:0]                             perf_windows,
  output logic [31:0]                             perf_stalls
`endif
);

  import conv_pkg::*;

  localparam int CNT_W = $clog2(READ_ADDR_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(READ_ADDR_LEN);
  localparam logic [CNT_W-1:0] CNT_RUN  = CNT_W'(READ_ADDR_LEN - 1);

  logic                                     w_accept;
  logic                                     w_fire;
  logic [INPUT_PREC-1:0]                    w_wr_ptr;
  logic [READ_ADDR_LEN-1:0][INPUT_PREC-1:0] w_window;
  state_t                                   r_state;
  state_t                                   w_state_nxt;
  logic [CNT_W-1:0]                         r_cnt;
  logic [CNT_W-1:0]                         w_cnt_nxt;
  logic                                     r_out_valid;
  logic                                     r_out_last;
  logic [READ_ADDR_LEN-1:0][INPUT_PREC-1:0] r_read_addr;

  // A held window blocks input so its addresses stay stable until consumed.
  assign in_ready = rst & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_fire   = w_accept & (r_state == RUN);

  assign wr_en   = w_accept;
  assign wr_addr = w_wr_ptr;
  assign wr_data = in_data;

  conv_ring_ptr #(
    .SIZE (MEMORY_SIZE),
    .W    (INPUT_PREC)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_accept),
    .o_ptr (w_wr_ptr)
  );

  // Window ending at the slot being written this cycle, oldest sample first.
  always_comb begin
    w_window = '0;
    for (int i = 0; i < READ_ADDR_LEN; i++) begin
      w_window[i] = INPUT_PREC'(wrap_sub(32'(w_wr_ptr),
                                         32'(READ_ADDR_LEN - 1 - i),
                                         32'(MEMORY_SIZE)));
    end
  end

  // Frame-fill FSM: count samples until a full window exists; in_last restarts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_accept) begin
      if (in_last) begin
        w_state_nxt = FILL;
        w_cnt_nxt   = '0;
      end else begin
        case (r_state)
          FILL: begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt + CNT_W'(1) == CNT_RUN) w_state_nxt = RUN;
          end
          RUN: begin
            if (r_cnt != CNT_FULL) w_cnt_nxt = r_cnt + CNT_W'(1);
          end
          default: begin
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  // FSM state and frame sample counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output window register: load on fire, hold under stall, clear on drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_read_addr <= '0;
    end else if (w_fire) begin
      r_out_valid <= 1'b1;
      r_out_last  <= in_last;
      r_read_addr <= w_window;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign read_addr = r_read_addr;

`ifdef CONV_WINDOW_PERF_CNT_EN
  logic [31:0] r_perf_windows;
  logic [31:0] r_perf_stalls;

  // Free-running wrap-around counters of window handshakes and stall cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_windows <= '0;
      r_perf_stalls  <= '0;
    end else begin
      if (r_out_valid & out_ready)  r_perf_windows <= r_perf_windows + 32'd1;
      if (r_out_valid & ~out_ready) r_perf_stalls  <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_windows = r_perf_windows;
  assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Self-checking bench for conv_window_addr_gen: directed scenarios with
// hand-computed windows plus a randomized phase compared every cycle against
// a frame-counting reference model. Honours CONV_WINDOW_PERF_CNT_EN.
module tb_conv_window_addr_gen;

  localparam int K = 8;
  localparam int M = 24;
  localparam int P = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [P-1:0]        in_data;
  logic                in_last;
  logic                wr_en;
  logic [P-1:0]        wr_addr;
  logic [P-1:0]        wr_data;
  logic [K-1:0][P-1:0] read_addr;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
`ifdef CONV_WINDOW_PERF_CNT_EN
  logic [31:0]         perf_windows;
  logic [31:0]         perf_stalls;
`endif

  conv_window_addr_gen #(
    .MEMORY_SIZE   (M),
    .READ_ADDR_LEN (K),
    .INPUT_PREC    (P)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .read_addr (read_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
`ifdef CONV_WINDOW_PERF_CNT_EN
    ,.perf_windows (perf_windows)
    ,.perf_stalls  (perf_stalls)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: counts samples per frame; once K are in the frame every
  // accepted sample yields the window of the K most recent buffer slots.
  int                  m_wrptr;
  int                  m_cnt;
  logic                m_valid;
  logic                m_last;
  logic [K-1:0][P-1:0] m_addr;

  always @(posedge clk) begin
    logic acc;
    acc = rst && in_valid && (!m_valid || out_ready);
    if (!rst) begin
      m_wrptr = 0;
      m_cnt   = 0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_addr  = '0;
    end else if (acc) begin
      if (m_cnt < 1000) m_cnt++;
      if (m_cnt >= K) begin
        m_valid = 1'b1;
        m_last  = in_last;
        for (int i = 0; i < K; i++) m_addr[i] = P'((m_wrptr - (K - 1) + i + M) % M);
      end else if (out_ready) begin
        m_valid = 1'b0;
        m_last  = 1'b0;
      end
      m_wrptr = (m_wrptr + 1) % M;
      if (in_last) m_cnt = 0;
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_last  = 1'b0;
    end
  end

  // Compare all outputs against the model in the middle of every cycle.
  always @(negedge clk) begin
    logic mir;
    if (chk_en) begin
      mir = rst && (!m_valid || out_ready);
      chk("m_in_ready", 64'(in_ready), 64'(mir));
      chk("m_wr_en", 64'(wr_en), 64'(mir && in_valid));
      if (mir && in_valid) begin
        chk("m_wr_addr", 64'(wr_addr), 64'(m_wrptr));
        chk("m_wr_data", 64'(wr_data), 64'(in_data));
      end
      chk("m_out_valid", 64'(out_valid), 64'(m_valid));
      chk("m_out_last", 64'(out_last), 64'(m_last));
      if (m_valid) chk("m_read_addr", 64'(read_addr), 64'(m_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int d, input bit l);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    in_valid = 1'b1;
    in_data  = P'(d);
    in_last  = l;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    chk("send_accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    in_last  = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_read_addr", 64'(read_addr), 64'(0));
    tick();
    rst      = 1'b1;
    in_valid = 1'b0;
  endtask

  // Window of K consecutive buffer slots starting at 'first' (mod M).
  task automatic chk_win(input string name, input int first, input bit last);
    chk({name, "_valid"}, 64'(out_valid), 64'(1));
    chk({name, "_last"}, 64'(out_last), 64'(last));
    for (int i = 0; i < K; i++) chk({name, "_addr"}, 64'(read_addr[i]), 64'((first + i) % M));
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Basic frame of 10 samples.
    do_reset();
    for (int s = 1; s <= 10; s++) begin
      send(s, s == 10);
      if (s < 8) chk("s1_no_window", 64'(out_valid), 64'(0));
      else chk_win("s1_win", s - 8, s == 10);
    end
    tick();
    chk("s1_drained", 64'(out_valid), 64'(0));

    // Write pointer wrap.
    do_reset();
    for (int s = 1; s <= 30; s++) begin
      send(s, s == 30);
      if (s == 26) chk_win("s2_wrap", 18, 1'b0);
    end
    tick();

    // Back-pressure for 5 cycles, then full-rate resume.
    do_reset();
    for (int s = 1; s <= 8; s++) send(s, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd9;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("s3_stall_in_ready", 64'(in_ready), 64'(0));
      chk("s3_stall_wr_en", 64'(wr_en), 64'(0));
      chk_win("s3_hold", 0, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    send(9, 1'b0);
    chk_win("s3_resume", 1, 1'b0);
    send(10, 1'b0);
    chk_win("s3_resume", 2, 1'b0);
    send(11, 1'b1);
    chk_win("s3_resume", 3, 1'b1);
    tick();
    chk("s3_drained", 64'(out_valid), 64'(0));
`ifdef CONV_WINDOW_PERF_CNT_EN
    chk("perf_stalls", 64'(perf_stalls), 64'(5));
    chk("perf_windows", 64'(perf_windows), 64'(4));
`endif

    // Short frame dropped, next frame windowed on its own samples only.
    do_reset();
    for (int s = 1; s <= 5; s++) begin
      send(s, s == 5);
      chk("s4_short_frame", 64'(out_valid), 64'(0));
    end
    for (int s = 1; s <= 8; s++) begin
      send(100 + s, s == 8);
      if (s < 8) chk("s4_fill", 64'(out_valid), 64'(0));
      else chk_win("s4_frame2", 5, 1'b1);
    end
    tick();

    // Reset in the middle of a frame.
    do_reset();
    for (int s = 1; s <= 6; s++) send(s, 1'b0);
    do_reset();
    for (int s = 1; s <= 8; s++) begin
      send(s, 1'b0);
      if (s < 8) chk("s5_fill", 64'(out_valid), 64'(0));
      else chk_win("s5_post_rst", 0, 1'b0);
    end
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = P'($urandom);
      in_last   = ($urandom_range(0, 11) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
